// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave cook-time controller.
// QUICK_START_EN adds the QLOAD state used by the one-touch 0:30 start.
package mw_pkg;

    localparam int DIGIT_W    = 4;
    localparam int KEYPAD_W   = 10;
    localparam int QUICK_TENS = 3;
    localparam int QUICK_ONES = 0;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        COOK,
        PAUSE,
`ifdef QUICK_START_EN
        DONE,
        QLOAD
`else
        DONE
`endif
    } state_t;

    function automatic logic is_one_hot(input logic [KEYPAD_W-1:0] keys);
        return $onehot(keys);
    endfunction

    function automatic logic [DIGIT_W-1:0] key_digit(input logic [KEYPAD_W-1:0] keys);
        logic [DIGIT_W-1:0] digit;
        digit = '0;
        for (int i = 0; i < KEYPAD_W; i++) begin
            if (keys[i]) digit = DIGIT_W'(i);
        end
        return digit;
    endfunction

endpackage

// File: rtl/microwave_ctrl_tick_gen.sv
// One-second tick divider: counts 0..TICK_DIV-1 while run is high and
// holds its count otherwise so a paused cook keeps its partial second.
module tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clock,
    input  logic clrn,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Door/start/stop sequencer for the cook-time timer: keypad loads, 1 s enables,
// magnetron drive and end-of-cook beep. QUICK_START_EN enables the 0:30 quick start.
//
// state | meaning
// IDLE  | timer idle, waiting for a digit (or quick start)
// SET   | digits being entered, waiting for start
// COOK  | magnetron on, timer counting down
// PAUSE | cook interrupted by door or stop, divider count held
// DONE  | end-of-cook beep
// QLOAD | quick start shifting 3 then 0 into the timer
module microwave_ctrl
    import mw_pkg::*;
#(
    parameter int TICK_DIV    = 100,
    parameter int BEEP_CYCLES = 300
) (
    input  logic                clock,
    input  logic                clrn,
    input  logic [KEYPAD_W-1:0] keypad,
    input  logic                startn,
    input  logic                stopn,
    input  logic                door_closed,
    input  logic                zero,
    output logic [DIGIT_W-1:0]  data,
    output logic                loadn,
    output logic                timer_clrn,
    output logic                en,
    output logic                mag_on,
    output logic                done_beep
);

    localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);

    state_t              state, state_d;
    logic [KEYPAD_W-1:0] keypad_prev;
    logic                startn_prev, stopn_prev;
    logic [BEEP_W-1:0]   beep_cnt, beep_cnt_d;
    logic [DIGIT_W-1:0]  data_d;
    logic                loadn_d, timer_clrn_d, en_d;
    logic                run, restart, tick;
    logic                key_evt, start_evt, stop_evt, door_open;
`ifdef QUICK_START_EN
    logic                q_step, q_step_d;
`endif

    assign key_evt   = is_one_hot(keypad) && (keypad_prev == '0);
    assign start_evt = startn_prev && !startn;
    assign stop_evt  = stopn_prev && !stopn;
    assign door_open = !door_closed;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock   (clock),
        .clrn    (clrn),
        .run     (run),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d      = state;
        data_d       = data;
        loadn_d      = 1'b1;
        timer_clrn_d = 1'b1;
        en_d         = 1'b0;
        run          = 1'b0;
        restart      = 1'b0;
        beep_cnt_d   = beep_cnt;
`ifdef QUICK_START_EN
        q_step_d     = q_step;
`endif
        case (state)
            IDLE: begin
                if (stop_evt) begin
                    timer_clrn_d = 1'b0;
                end else if (start_evt) begin
`ifdef QUICK_START_EN
                    if (zero && door_closed) begin
                        state_d  = QLOAD;
                        loadn_d  = 1'b0;
                        data_d   = DIGIT_W'(QUICK_TENS);
                        q_step_d = 1'b0;
                    end
`endif
                end else if (key_evt) begin
                    state_d = SET;
                    loadn_d = 1'b0;
                    data_d  = key_digit(keypad);
                end
            end
            SET: begin
                if (stop_evt) begin
                    state_d      = IDLE;
                    timer_clrn_d = 1'b0;
                end else if (start_evt) begin
                    if (door_closed && !zero) begin
                        state_d = COOK;
                        restart = 1'b1;
                    end
                end else if (key_evt) begin
                    loadn_d = 1'b0;
                    data_d  = key_digit(keypad);
                end
            end
            COOK: begin
                // The divider only advances on cycles where cooking continues,
                // so an interrupting cycle never loses a count.
                if (door_open || stop_evt) begin
                    state_d = PAUSE;
                end else if (zero) begin
                    state_d    = DONE;
                    beep_cnt_d = BEEP_LAST;
                end else begin
                    run  = 1'b1;
                    en_d = tick;
                end
            end
            PAUSE: begin
                if (stop_evt) begin
                    state_d      = IDLE;
                    timer_clrn_d = 1'b0;
                    restart      = 1'b1;
                end else if (start_evt && door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (door_open || stop_evt || start_evt || key_evt) begin
                    state_d = IDLE;
                end else if (beep_cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    beep_cnt_d = beep_cnt - BEEP_W'(1);
                end
            end
`ifdef QUICK_START_EN
            QLOAD: begin
                if (door_open) begin
                    state_d = IDLE;
                end else if (!q_step) begin
                    loadn_d  = 1'b0;
                    data_d   = DIGIT_W'(QUICK_ONES);
                    q_step_d = 1'b1;
                end else begin
                    state_d = COOK;
                    restart = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            keypad_prev <= '0;
            startn_prev <= 1'b1;
            stopn_prev  <= 1'b1;
            beep_cnt    <= '0;
            data        <= '0;
            loadn       <= 1'b1;
            timer_clrn  <= 1'b0;
            en          <= 1'b0;
            mag_on      <= 1'b0;
            done_beep   <= 1'b0;
`ifdef QUICK_START_EN
            q_step      <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            keypad_prev <= keypad;
            startn_prev <= startn;
            stopn_prev  <= stopn;
            beep_cnt    <= beep_cnt_d;
            data        <= data_d;
            loadn       <= loadn_d;
            timer_clrn  <= timer_clrn_d;
            en          <= en_d;
            mag_on      <= (state_d == COOK);
            done_beep   <= (state_d == DONE);
`ifdef QUICK_START_EN
            q_step      <= q_step_d;
`endif
        end
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: load pulses go through a scoreboard
// queue, timing of en/mag_on/done_beep/timer_clrn is checked cycle by cycle.
module tb_microwave_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int BEEP_CYCLES = 6;

    logic       clock = 1'b0;
    logic       clrn  = 1'b0;
    logic [9:0] keypad = '0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic       zero = 1'b0;
    logic [3:0] data;
    logic       loadn, timer_clrn, en, mag_on, done_beep;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int mon_exp;

    microwave_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_CYCLES(BEEP_CYCLES)) dut (
        .clock       (clock),
        .clrn        (clrn),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .zero        (zero),
        .data        (data),
        .loadn       (loadn),
        .timer_clrn  (timer_clrn),
        .en          (en),
        .mag_on      (mag_on),
        .done_beep   (done_beep)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int d, input bit accept);
        keypad = 10'(1 << d);
        if (accept) sb.push_back(d);
        nc(1);
        check("key_load", int'(loadn), accept ? 0 : 1);
        keypad = '0;
        nc(1);
        check("key_load_end", int'(loadn), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_loadn"}, int'(loadn), 1);
        check({tag, "_tclrn"}, int'(timer_clrn), 0);
        check({tag, "_en"}, int'(en), 0);
        check({tag, "_mag"}, int'(mag_on), 0);
        check({tag, "_beep"}, int'(done_beep), 0);
    endtask

    // Every load strobe must match the oldest expected digit.
    always @(negedge clock) begin
        if (clrn && !loadn) begin
            if (sb.size() == 0) begin
                check("load_unexp", int'(loadn), 1);
            end else begin
                mon_exp = sb.pop_front();
                check("load_data", int'(data), mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nc(1);
        check_reset_values("rst");
        clrn = 1'b1;
        nc(1);
        check("rst_rel_tclrn", int'(timer_clrn), 1);

        press(1, 1'b1);
        press(5, 1'b1);

        // Full cook: en every 4 cycles, zero after 3 ticks, beep, back to idle.
        press(0, 1'b1);
        press(3, 1'b1);
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            check("cook_en", int'(en), (k == 5 || k == 9 || k == 13) ? 1 : 0);
            check("cook_mag", int'(mag_on), (k <= 13) ? 1 : 0);
            check("cook_beep", int'(done_beep), (k >= 14 && k <= 19) ? 1 : 0);
            if (k == 13) zero = 1'b1;
            nc(1);
        end
        zero = 1'b0;

        // Pause at divider count 2, resume, next en after one more count.
        press(2, 1'b1);
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            check("pause_en", int'(en), (k == 5 || k == 14 || k == 18) ? 1 : 0);
            check("pause_mag", int'(mag_on), (k <= 7 || k >= 12) ? 1 : 0);
            if (k == 7)  door_closed = 1'b0;
            if (k == 10) door_closed = 1'b1;
            if (k == 11) startn = 1'b0;
            if (k == 12) startn = 1'b1;
            nc(1);
        end

        door_closed = 1'b0;
        stopn = 1'b0;
        nc(1);
        check("door_stop_mag", int'(mag_on), 0);
        check("door_stop_tclrn", int'(timer_clrn), 1);
        check("door_stop_en", int'(en), 0);
        stopn = 1'b1;
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
        check("open_start_mag", int'(mag_on), 0);
        nc(1);
        check("open_start_mag2", int'(mag_on), 0);
        door_closed = 1'b1;
        stopn = 1'b0;
        nc(1);
        check("pause_stop_clr", int'(timer_clrn), 0);
        stopn = 1'b1;
        nc(1);
        check("pause_stop_clr_end", int'(timer_clrn), 1);
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
        check("idle_start_mag", int'(mag_on), 0);
        nc(1);
        check("idle_start_mag2", int'(mag_on), 0);

        // Multi-key pattern, key during cook, zero coinciding with a tick.
        keypad = 10'h003;
        nc(1);
        check("multi_key", int'(loadn), 1);
        keypad = '0;
        nc(1);
        press(4, 1'b1);
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
        check("cook2_mag", int'(mag_on), 1);
        press(7, 1'b0);
        nc(1);
        zero = 1'b1;
        nc(1);
        check("zero_tick_en", int'(en), 0);
        check("zero_tick_beep", int'(done_beep), 1);
        check("zero_tick_mag", int'(mag_on), 0);
        stopn = 1'b0;
        nc(1);
        check("beep_stop", int'(done_beep), 0);
        check("beep_stop_tclrn", int'(timer_clrn), 1);
        stopn = 1'b1;
        zero = 1'b0;
        nc(1);
        check("beep_stop_tclrn2", int'(timer_clrn), 1);

        // Stop in SET clears the timer and returns to IDLE.
        press(8, 1'b1);
        stopn = 1'b0;
        nc(1);
        check("set_stop_clr", int'(timer_clrn), 0);
        stopn = 1'b1;
        nc(1);
        check("set_stop_clr_end", int'(timer_clrn), 1);
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
        check("set_stop_idle_mag", int'(mag_on), 0);
        nc(1);

        // Asynchronous reset while cooking.
        press(9, 1'b1);
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
        nc(4);
        check("pre_rst_en", int'(en), 1);
        check("pre_rst_mag", int'(mag_on), 1);
        clrn = 1'b0;
        #1;
        check_reset_values("mid_rst");
        nc(1);
        clrn = 1'b1;
        nc(1);
        check("post_rst_tclrn", int'(timer_clrn), 1);
        check("post_rst_mag", int'(mag_on), 0);

        // Start in IDLE with the timer at 0:00.
        zero = 1'b1;
`ifdef QUICK_START_EN
        sb.push_back(3);
        sb.push_back(0);
`endif
        startn = 1'b0;
        nc(1);
        startn = 1'b1;
`ifdef QUICK_START_EN
        check("quick_load1", int'(loadn), 0);
        nc(1);
        check("quick_load2", int'(loadn), 0);
        nc(1);
        check("quick_cook", int'(mag_on), 1);
`else
        check("quick_none1", int'(loadn), 1);
        nc(1);
        check("quick_none2", int'(loadn), 1);
        nc(1);
        check("quick_none_mag", int'(mag_on), 0);
`endif
        zero = 1'b0;
        nc(10);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
